sb_rx_transaction_parser: RTL
=============================

# sb_rx_transaction_parser

Sideband receive front end for the logical layer. It deframes the serial `sbrx` line at one bit per `sb_clk` cycle into bytes, then parses USB4 sideband transactions from that byte stream:

- LT transactions (DLE, LSE, CLSE) are delivered as one checked LSE byte.
- AT transactions (DLE, STX, payload, CRC, DLE, ETX) are delivered as destuffed payload bytes with a CRC verdict.

It sits directly downstream of the electrical-layer `sbrx` pin and feeds the link FSM and AT handler.

## Interface
- `MAX_AT_BYTES`, default 64: maximum destuffed payload bytes per AT transaction, excluding the two CRC bytes.
- `sb_clk` in 1: sideband clock, one bit period per cycle.
- `rst` in 1: synchronous, active-high reset.
- `sbrx` in 1: serial line, idles high.
- `at_data` out 8: AT payload byte.
- `at_valid` out 1: `at_data` is valid this cycle.
- `at_sop` out 1: marks the first payload byte of a transaction; only meaningful while `at_valid` is high.
- `at_is_rsp` out 1: set for STX_RSP, clear for STX_CMD; held from STX until the next STX.
- `at_done` out 1: one-cycle pulse at AT end.
- `at_crc_ok` out 1: CRC verdict, valid while `at_done` is high.
- `lt_valid` out 1: one-cycle pulse when an LT transaction is accepted.
- `lt_lse` out 8: the accepted LSE byte, held until the next `lt_valid`.
- `err_framing` out 1: one-cycle pulse on a bad stop bit, a bad DLE sequence, or a CLSE mismatch.
- `err_overflow` out 1: one-cycle pulse when the payload exceeds `MAX_AT_BYTES`, or when fewer than 2 bytes precede DLE ETX.

## Operation

Bit deframer, states B_IDLE, B_DATA, B_STOP, B_WAIT_HIGH:
- **B_IDLE:** `sbrx`=0 is the start bit; go to B_DATA.
- **B_DATA:** 8 cycles, LSB first; 3-bit counter.
- **B_STOP:**
  - `sbrx`=1: byte strobe asserts next cycle; go to B_IDLE.
  - `sbrx`=0: `err_framing`, byte discarded, go to B_WAIT_HIGH.
- **B_WAIT_HIGH:** leave on the first `sbrx`=1.
- A framing error also forces the transaction FSM to T_IDLE.

Transaction FSM, states T_IDLE, T_GOT_DLE, T_LT, T_AT_BODY, T_AT_DLE. All moves happen only on a byte strobe.
- **T_IDLE:** DLE goes to T_GOT_DLE. Any other byte is ignored.
- **T_GOT_DLE:**
  - STX_CMD or STX_RSP: set `at_is_rsp`, init CRC, clear holdback and count, go to T_AT_BODY.
  - DLE: stay.
  - ETX: go to T_IDLE.
  - Any other byte: latch it as the candidate LSE, go to T_LT.
- **T_LT:**
  - byte == ~candidate: `lt_valid`, `lt_lse` = candidate.
  - Otherwise: `err_framing`.
  - Go to T_IDLE in either case.
- **T_AT_BODY:**
  - DLE goes to T_AT_DLE.
  - Any other byte is pushed.
- **T_AT_DLE:**
  - DLE: push 0xFE, return to T_AT_BODY.
  - ETX: end the transaction.
  - Other: `err_framing`, go to T_IDLE.

Push and holdback:
- A 2-entry holdback delays output, so the final two bytes (the CRC) are never emitted.
- A push into a full holdback emits the oldest byte as `at_data`/`at_valid` and updates the CRC with that byte.
- `at_sop` is set on the first emitted byte.
- If the emitted count would exceed `MAX_AT_BYTES`: `err_overflow`, go to T_IDLE, no `at_done`.

End of transaction:
- Fewer than 2 held bytes: `err_overflow`, go to T_IDLE.
- Otherwise the received CRC is {newer, older}: the older byte is the low byte, sent first.
- `at_done`=1 and `at_crc_ok` = (computed == received). Go to T_IDLE.

CRC definition:
- CRC-16/MODBUS: reflected polynomial 0xA001, init 0xFFFF, no final XOR, byte LSB first.
- Covers the destuffed payload only (not STX, not the CRC bytes).

Reset:
- All outputs go to 0; `lt_lse`=0, `at_is_rsp`=0.
- FSMs go to B_IDLE and T_IDLE; holdback and count are cleared.
- Reset mid-byte or mid-transaction discards all partial state.

## Timing
- Byte strobe occurs one cycle after the stop-bit sample.
- The following are registered from that strobe, asserting one cycle after it (two cycles after the stop bit): `at_valid`, `lt_valid`, `at_done`, `err_*`.
- At most one output pulse per byte strobe. Bytes arrive at most every 10 cycles, so no backpressure exists and none is provided.
- Back-to-back frames are legal: a start bit may be sampled in the cycle immediately after a good stop bit.

## Structure
- Shared package `sb_pkg` holds:
  - constants DLE=8'hFE, STX_CMD=8'h05, STX_RSP=8'h04, ETX=8'h40, CRC_INIT=16'hFFFF;
  - the state enums for both FSMs;
  - function `crc16_byte(crc, byte)`.
- One sub-module, `sb_uart_deframer` (the bit deframer), outputs `byte_data`/`byte_strobe`/`stop_err`. The transaction FSM, holdback and CRC stay in the top.

## Test plan
- **LT accept:** frames FE, 3A, C5 → `lt_valid` pulse, `lt_lse`=8'h3A, no errors.
- **LT mismatch:** FE, 3A, C4 → `err_framing`, no `lt_valid`.
- **AT command:** FE, 05, "123456789", 37, 4B, FE, 40 →
  - 9 `at_valid` bytes 31..39, `at_sop` on 31, `at_is_rsp`=0;
  - `at_done` with `at_crc_ok`=1.
  - Repeat with CRC 37, 4C → `at_crc_ok`=0.
- **DLE stuffing:** payload FE FE inside an STX_RSP body → one 0xFE emitted, `at_is_rsp`=1, CRC computed over the destuffed byte.
- **Stop-bit error** mid-AT (`sbrx`=0 at the stop cycle) → `err_framing`, no `at_done`. A following clean LT transaction is accepted.
- **Overflow:** `MAX_AT_BYTES`=4 with 7 payload bytes → `err_overflow` on the 5th emit. Separately, `rst`=1 for 1 cycle during B_DATA → all outputs 0 and the next full frame parses correctly.

Source files
------------

// File: rtl/sb_pkg.sv
// Sideband receive shared definitions: control bytes, FSM state encodings, CRC step.
// Latency: n/a (constants, types and a pure combinational function).
// Backpressure: n/a.
package sb_pkg;

  localparam logic [7:0]  DLE      = 8'hFE;
  localparam logic [7:0]  STX_CMD  = 8'h05;
  localparam logic [7:0]  STX_RSP  = 8'h04;
  localparam logic [7:0]  ETX      = 8'h40;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    B_IDLE,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } bit_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_GOT_DLE,
    T_LT,
    T_AT_BODY,
    T_AT_DLE
  } txn_state_e;

  // CRC-16/MODBUS step over one byte: reflected poly 0xA001, byte consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_uart_deframer.sv
// Bit deframer: start bit, 8 data bits LSB first, stop bit -> one byte per frame.
// Latency: byte_strobe/stop_err assert one cycle after the stop-bit sample.
// Backpressure: none; consumer must take each byte on its strobe.
module sb_uart_deframer
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       stop_err
);

  bit_state_e state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q;
  logic [7:0] byte_data_q;
  logic       byte_strobe_q;
  logic       stop_err_q;

  // Frame FSM; a low stop bit discards the byte and waits for the line to return high.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q       <= B_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      byte_data_q   <= '0;
      byte_strobe_q <= 1'b0;
      stop_err_q    <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      stop_err_q    <= 1'b0;
      case (state_q)
        B_IDLE: begin
          if (!sbrx) begin
            state_q <= B_DATA;
            cnt_q   <= '0;
          end
        end
        B_DATA: begin
          shift_q <= {sbrx, shift_q[7:1]};
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= B_STOP;
        end
        B_STOP: begin
          if (sbrx) begin
            byte_data_q   <= shift_q;
            byte_strobe_q <= 1'b1;
            state_q       <= B_IDLE;
          end else begin
            stop_err_q <= 1'b1;
            state_q    <= B_WAIT_HIGH;
          end
        end
        B_WAIT_HIGH: begin
          if (sbrx) state_q <= B_IDLE;
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_strobe = byte_strobe_q;
  assign stop_err    = stop_err_q;

endmodule

// File: rtl/sb_rx_transaction_parser.sv
// Sideband RX parser: deframes sbrx, then decodes LT (checked LSE) and AT (destuffed payload + CRC verdict).
// Latency: result pulses assert two cycles after the stop bit of the deciding byte.
// Backpressure: none; at most one byte per 10 cycles, outputs are fire-and-forget pulses.
module sb_rx_transaction_parser
  import sb_pkg::*;
#(
  parameter int unsigned MAX_AT_BYTES = 64
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] at_data,
  output logic       at_valid,
  output logic       at_sop,
  output logic       at_is_rsp,
  output logic       at_done,
  output logic       at_crc_ok,
  output logic       lt_valid,
  output logic [7:0] lt_lse,
  output logic       err_framing,
  output logic       err_overflow
);

  localparam int CW = $clog2(MAX_AT_BYTES + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_AT_BYTES);

  logic [7:0] byte_data;
  logic       byte_strobe;
  logic       stop_err;

  sb_uart_deframer u_deframer (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .sbrx        (sbrx),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .stop_err    (stop_err)
  );

  txn_state_e    t_state_q;
  logic [7:0]    cand_q;
  logic [7:0]    hb0_q;      // older held byte
  logic [7:0]    hb1_q;      // newer held byte
  logic [1:0]    hb_cnt_q;
  logic [CW-1:0] emit_cnt_q;
  logic [15:0]   crc_q;

  logic [7:0] at_data_q;
  logic       at_valid_q, at_sop_q, at_is_rsp_q, at_done_q, at_crc_ok_q;
  logic       lt_valid_q, err_framing_q, err_overflow_q;
  logic [7:0] lt_lse_q;

  logic push_vld;

  // A payload byte enters the holdback on a plain body byte or on a stuffed DLE pair.
  always_comb begin
    push_vld = 1'b0;
    if (byte_strobe) begin
      if (t_state_q == T_AT_BODY && byte_data != DLE) push_vld = 1'b1;
      if (t_state_q == T_AT_DLE  && byte_data == DLE) push_vld = 1'b1;
    end
  end

  // Transaction FSM with holdback, CRC and registered output pulses.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      t_state_q      <= T_IDLE;
      cand_q         <= '0;
      hb0_q          <= '0;
      hb1_q          <= '0;
      hb_cnt_q       <= '0;
      emit_cnt_q     <= '0;
      crc_q          <= CRC_INIT;
      at_data_q      <= '0;
      at_valid_q     <= 1'b0;
      at_sop_q       <= 1'b0;
      at_is_rsp_q    <= 1'b0;
      at_done_q      <= 1'b0;
      at_crc_ok_q    <= 1'b0;
      lt_valid_q     <= 1'b0;
      lt_lse_q       <= '0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      at_valid_q     <= 1'b0;
      at_sop_q       <= 1'b0;
      at_done_q      <= 1'b0;
      lt_valid_q     <= 1'b0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      if (stop_err) begin
        err_framing_q <= 1'b1;
        t_state_q     <= T_IDLE;
      end else if (byte_strobe) begin
        case (t_state_q)
          T_IDLE: begin
            if (byte_data == DLE) t_state_q <= T_GOT_DLE;
          end
          T_GOT_DLE: begin
            if (byte_data == STX_CMD || byte_data == STX_RSP) begin
              at_is_rsp_q <= (byte_data == STX_RSP);
              crc_q       <= CRC_INIT;
              hb_cnt_q    <= '0;
              emit_cnt_q  <= '0;
              t_state_q   <= T_AT_BODY;
            end else if (byte_data == DLE) begin
              t_state_q <= T_GOT_DLE;
            end else if (byte_data == ETX) begin
              t_state_q <= T_IDLE;
            end else begin
              cand_q    <= byte_data;
              t_state_q <= T_LT;
            end
          end
          T_LT: begin
            if (byte_data == ~cand_q) begin
              lt_valid_q <= 1'b1;
              lt_lse_q   <= cand_q;
            end else begin
              err_framing_q <= 1'b1;
            end
            t_state_q <= T_IDLE;
          end
          T_AT_BODY: begin
            if (byte_data == DLE) t_state_q <= T_AT_DLE;
          end
          T_AT_DLE: begin
            if (byte_data == DLE) begin
              t_state_q <= T_AT_BODY;
            end else if (byte_data == ETX) begin
              // The two held bytes are the CRC, low byte first on the wire.
              if (hb_cnt_q != 2'd2) begin
                err_overflow_q <= 1'b1;
              end else begin
                at_done_q   <= 1'b1;
                at_crc_ok_q <= (crc_q == {hb1_q, hb0_q});
              end
              t_state_q <= T_IDLE;
            end else begin
              err_framing_q <= 1'b1;
              t_state_q     <= T_IDLE;
            end
          end
          default: t_state_q <= T_IDLE;
        endcase

        // Holdback: fill two slots, then each push releases the oldest byte.
        if (push_vld) begin
          if (hb_cnt_q == 2'd0) begin
            hb0_q    <= byte_data;
            hb_cnt_q <= 2'd1;
          end else if (hb_cnt_q == 2'd1) begin
            hb1_q    <= byte_data;
            hb_cnt_q <= 2'd2;
          end else if (emit_cnt_q == MAX_C) begin
            err_overflow_q <= 1'b1;
            t_state_q      <= T_IDLE;
          end else begin
            at_data_q  <= hb0_q;
            at_valid_q <= 1'b1;
            at_sop_q   <= (emit_cnt_q == '0);
            crc_q      <= crc16_byte(crc_q, hb0_q);
            emit_cnt_q <= emit_cnt_q + 1'b1;
            hb0_q      <= hb1_q;
            hb1_q      <= byte_data;
          end
        end
      end
    end
  end

  assign at_data      = at_data_q;
  assign at_valid     = at_valid_q;
  assign at_sop       = at_sop_q;
  assign at_is_rsp    = at_is_rsp_q;
  assign at_done      = at_done_q;
  assign at_crc_ok    = at_crc_ok_q;
  assign lt_valid     = lt_valid_q;
  assign lt_lse       = lt_lse_q;
  assign err_framing  = err_framing_q;
  assign err_overflow = err_overflow_q;

endmodule
